// File: rtl/cpu_pkg.sv
// cpu_pkg: shared fetch-path types and constants
package cpu_pkg;
    typedef enum logic [1:0] {FETCH_REQ, FETCH_WAIT, FETCH_HOLD, FETCH_DRAIN} fetch_state_t;
    localparam int INSTR_BYTES = 4;
endpackage

// File: rtl/fetch_pc_next.sv
// fetch_pc_next: next fetch PC selection (redirect beats sequential advance) and misalignment detect
module fetch_pc_next
    import cpu_pkg::*;
#(
    parameter int ADDR_WIDTH = 16
) (
    input  logic [ADDR_WIDTH-1:0] fetchPC,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH-1:0] redirectPC,
    input  logic                  advance,
    output logic [ADDR_WIDTH-1:0] nextPC,
    output logic                  misaligned
);
    // Redirect targets are word-aligned by dropping the low bits; the sequential step wraps naturally
    always_comb begin
        nextPC     = redirect ? {redirectPC[ADDR_WIDTH-1:2], 2'b00}
                   : advance  ? fetchPC + ADDR_WIDTH'(INSTR_BYTES)
                   : fetchPC;
        misaligned = redirect && (redirectPC[1:0] != 2'b00);
    end
endmodule

// File: rtl/fetch_controller.sv
// fetch_controller: single-outstanding instruction fetch sequencer with redirect and decode handshake
module fetch_controller
    import cpu_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 16,
    parameter int                    INSTR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
    parameter int                    CNT_WIDTH   = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   redirect,
    input  logic [ADDR_WIDTH-1:0]  redirectPC,
    output logic                   memReq,
    output logic [ADDR_WIDTH-1:0]  memAddr,
    input  logic                   memGnt,
    input  logic                   memRvalid,
    input  logic [INSTR_WIDTH-1:0] memRdata,
    output logic                   instrValid,
    input  logic                   instrReady,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0]  instrPC,
    output logic                   alignErr,
    output logic [CNT_WIDTH-1:0]   fetchCount
);
    fetch_state_t            state_q, state_d;
    logic [ADDR_WIDTH-1:0]   fetch_pc_q, fetch_pc_d;
    logic [INSTR_WIDTH-1:0]  instr_q, instr_d;
    logic [ADDR_WIDTH-1:0]   instr_pc_q, instr_pc_d;
    logic                    valid_q, valid_d;
    logic                    align_err_q;
    logic [CNT_WIDTH-1:0]    count_q;
    logic                    handshake, load, misaligned;

    assign handshake = valid_q && instrReady;
    assign load      = (state_q == FETCH_WAIT) && memRvalid && !redirect;

    fetch_pc_next #(.ADDR_WIDTH(ADDR_WIDTH)) u_pc_next (
        .fetchPC    (fetch_pc_q),
        .redirect   (redirect),
        .redirectPC (redirectPC),
        .advance    (handshake),
        .nextPC     (fetch_pc_d),
        .misaligned (misaligned)
    );

    // Next state and decode-side output registers; redirect overrides every other event
    always_comb begin
        state_d    = state_q;
        instr_d    = load ? memRdata : instr_q;
        instr_pc_d = load ? fetch_pc_q : instr_pc_q;
        valid_d    = load || (valid_q && !instrReady && !redirect);
        unique case (state_q)
            FETCH_REQ:   state_d = memGnt ? (redirect ? FETCH_DRAIN : FETCH_WAIT) : FETCH_REQ;
            FETCH_WAIT:  state_d = memRvalid ? (redirect ? FETCH_REQ : FETCH_HOLD)
                                 : (redirect ? FETCH_DRAIN : FETCH_WAIT);
            FETCH_HOLD:  state_d = (redirect || instrReady) ? FETCH_REQ : FETCH_HOLD;
            FETCH_DRAIN: state_d = memRvalid ? FETCH_REQ : FETCH_DRAIN;
        endcase
    end

    // State, PC, output registers, sticky alignment flag and retired-fetch counter
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= FETCH_REQ;
            fetch_pc_q  <= RESET_PC;
            instr_q     <= '0;
            instr_pc_q  <= '0;
            valid_q     <= 1'b0;
            align_err_q <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            instr_q     <= instr_d;
            instr_pc_q  <= instr_pc_d;
            valid_q     <= valid_d;
            align_err_q <= align_err_q || misaligned;
            count_q     <= count_q + CNT_WIDTH'(handshake);
        end
    end

    assign memReq     = rst && (state_q == FETCH_REQ);
    assign memAddr    = fetch_pc_q;
    assign instrValid = valid_q;
    assign instr      = instr_q;
    assign instrPC    = instr_pc_q;
    assign alignErr   = align_err_q;
    assign fetchCount = count_q;
endmodule
